dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one RV32I load/store at a time and
// answers after a fixed LATENCY, with byte-lane writes and sign/zero-extended loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid holds its payload stable until that edge, and ready may depend on state only.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t state, state_nxt;
  logic [3:0]  cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic        cur_err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] wr_word;
  logic        we;

  assign accept = req_valid && req_ready;

  // With LATENCY=1 the response is formed on the accept edge itself, so the live
  // request fields are used; otherwise the fields registered at accept are used.
  assign cur_write  = (state == IDLE) ? req_write  : r_write;
  assign cur_addr   = (state == IDLE) ? req_addr   : r_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : r_wdata;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : r_funct3;

  assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == 4'd1));

  always_comb begin
    cur_err = 1'b0;
    case (cur_funct3)
      3'b000:  cur_err = 1'b0;
      3'b001:  cur_err = cur_addr[0];
      3'b010:  cur_err = (cur_addr[1:0] != 2'b00);
      3'b100:  cur_err = cur_write;
      3'b101:  cur_err = cur_write || cur_addr[0];
      default: cur_err = 1'b1;
    endcase
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) cur_err = 1'b1;
  end

  assign idx      = cur_addr[AW+1:2];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    load_data = 32'd0;
    be        = 4'b0000;
    wr_word   = cur_wdata;
    case (cur_funct3)
      3'b000: begin
        load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
        be        = 4'b0001 << cur_addr[1:0];
        wr_word   = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
        be        = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{cur_wdata[15:0]}};
      end
      3'b010: begin
        load_data = rd_word;
        be        = 4'b1111;
      end
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  // Reset on the same edge must not let a pending store land.
  assign we = enter_resp && cur_write && !cur_err && !reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][i*8 +: 8] <= wr_word[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_write  <= req_write;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
        cnt      <= LAT_M1;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_err   <= cur_err;
        resp_rdata <= (cur_err || cur_write) ? 32'd0 : load_data;
      end else if ((state == RESP) && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: driver tasks push expected responses into a
// queue, and an independent monitor pops and compares on every response handshake.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DW  = 256;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  int total = 0;
  int bad = 0;

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Monitor: every response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && resp_valid && resp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got err=%0b rdata=%08h, none expected", resp_err, resp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          bad++;
          $display("FAIL resp_data: got err=%0b rdata=%08h, need err=%0b rdata=%08h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %08h need %08h", name, got, need);
    end
  endtask

  // Issues one request, then returns at the negedge where resp_valid is first seen.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input logic e, input logic [31:0] rd);
    int n;
    logic got;
    exp_q.push_back({e, rd});
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 need 1");
      return;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = resp_valid;
    end
    total++;
    if (!got || n != LAT) begin
      bad++;
      $display("FAIL latency: got %0d edges (valid=%0b) need %0d", n, got, LAT);
    end
  endtask

  task automatic complete();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic e, input logic [31:0] rd);
    issue(w, a, d, f3, e, rd);
    complete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_resp", {resp_valid, resp_err, dbg_state, resp_rdata[27:0]}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Word round trip and extension
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h13, 32'h0, 3'b000, 1'b0, 32'hFFFF_FFDE);
    xfer(1'b0, 32'h13, 32'h0, 3'b100, 1'b0, 32'h0000_00DE);
    xfer(1'b0, 32'h10, 32'h0, 3'b001, 1'b0, 32'hFFFF_BEEF);
    xfer(1'b0, 32'h12, 32'h0, 3'b101, 1'b0, 32'h0000_DEAD);

    // Partial store touches only its lane
    xfer(1'b1, 32'h11, 32'h0000_AB55, 3'b000, 1'b0, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_55EF);
    xfer(1'b0, 32'h11, 32'h0, 3'b000, 1'b0, 32'h0000_0055);

    // Errors: no data, no side effects
    xfer(1'b1, 32'h12, 32'h1111_1111, 3'b010, 1'b1, 32'h0);
    xfer(1'b0, 32'h01, 32'h0, 3'b001, 1'b1, 32'h0);
    xfer(1'b0, 32'(4 * DW), 32'h0, 3'b010, 1'b1, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 3'b011, 1'b1, 32'h0);
    xfer(1'b1, 32'h10, 32'h2222_2222, 3'b100, 1'b1, 32'h0);
    xfer(1'b1, 32'h10, 32'h3333_3333, 3'b111, 1'b1, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_55EF);

    // Backpressure with a stray request held during RESP
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_55EF);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {resp_valid, req_ready, resp_err, 29'd0} ^ resp_rdata,
            {1'b1, 1'b0, 1'b0, 29'd0} ^ 32'hDEAD_55EF);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", {30'd0, req_ready, resp_valid}, 32'd2);
    #1;
    xfer(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_55EF);

    // Reset while a store is in BUSY
    xfer(1'b1, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("reset_drops_resp", {31'd0, seen}, 32'd0);
    check("reset_req_ready_after", {31'd0, req_ready}, 32'd1);
    #1;
    xfer(1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
